// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned shift-add multiplier with HI/LO result registers.
// One multiplier bit per cycle; busy stalls the pipeline, done pulses on HI/LO update.
module multu_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [3:0]  signal,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);

  localparam logic [3:0] MULTU = 4'b0101;
  localparam logic [3:0] MFHI  = 4'b0110;
  localparam logic [3:0] MFLO  = 4'b0111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        go;
  logic [63:0] sum;

  assign go  = start && (signal == MULTU);
  assign sum = prod_q + (mplier_q[0] ? mcand_q : 64'h0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (go) begin
          mcand_d  = {32'h0, dataA};
          mplier_d = dataB;
          prod_d   = 64'h0;
          count_d  = 6'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        prod_d   = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 6'd1;
        // last bit: commit the sum including this cycle's add
        if (count_q == 6'd31) begin
          hi_d    = sum[63:32];
          lo_d    = sum[31:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= 64'h0;
      mplier_q <= 32'h0;
      prod_q   <= 64'h0;
      count_q  <= 6'd0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    unique case (1'b1)
      (signal == MFHI): dataOut = hi_q;
      (signal == MFLO): dataOut = lo_q;
      default:          dataOut = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo against a plain 64-bit product model.
// Directed corner cases plus randomized multiplies.
module tb_multu_hilo;

  localparam logic [3:0] SLL   = 4'b0011;
  localparam logic [3:0] SRL   = 4'b0100;
  localparam logic [3:0] MULTU = 4'b0101;
  localparam logic [3:0] MFHI  = 4'b0110;
  localparam logic [3:0] MFLO  = 4'b0111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [3:0]  signal;
  logic        start;
  logic        busy, done;
  logic [31:0] dataOut;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;
  logic [63:0] model;

  multu_hilo dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
    .signal(signal), .start(start), .busy(busy), .done(done),
    .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hilo(input string tag, input logic [63:0] exp);
    logic [3:0] s;
    s = signal;
    signal = MFHI; #1;
    check({tag, " hi"}, {32'h0, dataOut}, {32'h0, exp[63:32]});
    signal = MFLO; #1;
    check({tag, " lo"}, {32'h0, dataOut}, {32'h0, exp[31:0]});
    signal = s;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    dataA = a; dataB = b; signal = MULTU; start = 1'b1;
  endtask

  // Called at the negedge where start was raised; returns at the DONE negedge.
  task automatic finish_mult(input string tag, input logic [63:0] prev,
                             input bit mid, output int n);
    int nb = 0;
    n = 0;
    @(negedge clk);
    start = 1'b0; signal = 4'h0;
    dataA = $urandom; dataB = $urandom;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      if (mid && n == 5) begin
        check_hilo({tag, " mid"}, prev);
        dataA = 32'h0; dataB = 32'h0; signal = MULTU; start = 1'b1;
      end else begin
        start = 1'b0; signal = 4'h0;
      end
      n++;
      @(negedge clk);
    end
    check({tag, " busycyc"}, 64'(nb), 64'd32);
    check({tag, " done"}, {63'h0, done}, 64'd1);
    check({tag, " busy@done"}, {63'h0, busy}, 64'd0);
    check_hilo(tag, model);
  endtask

  task automatic do_mult(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input bit mid);
    int n, d0;
    logic [63:0] prev;
    prev = model;
    d0 = done_cnt;
    @(negedge clk);
    launch(a, b);
    model = {32'h0, a} * {32'h0, b};
    finish_mult(tag, prev, mid, n);
    @(negedge clk);
    #1;
    check({tag, " pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, " idle"}, {62'h0, busy, done}, 64'd0);
  endtask

  initial begin
    int n;
    logic [3:0] codes [3];
    codes[0] = SLL; codes[1] = SRL; codes[2] = 4'b0000;
    reset = 1'b0; start = 1'b0; signal = 4'h0;
    dataA = 32'h0; dataB = 32'h0;
    model = 64'h0;
    #2;
    check("rst busy", {63'h0, busy}, 64'd0);
    check("rst done", {63'h0, done}, 64'd0);
    check_hilo("rst", 64'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    do_mult("3x5", 32'd3, 32'd5, 1'b0);
    do_mult("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_mult("8x2", 32'h80000000, 32'd2, 1'b0);
    do_mult("7x6", 32'd7, 32'd6, 1'b1);

    // back-to-back: relaunch in the DONE cycle
    @(negedge clk);
    launch(32'd2, 32'd3);
    model = 64'd6;
    finish_mult("b2b1", 64'h0, 1'b0, n);
    launch(32'd4, 32'd5);
    model = 64'd20;
    finish_mult("b2b2", 64'h0, 1'b0, n);
    check("b2b gap", 64'(n + 1), 64'd33);
    @(negedge clk);

    // reset in the middle of a run
    @(negedge clk);
    launch(32'h1234, 32'h5678);
    @(negedge clk);
    start = 1'b0; signal = 4'h0;
    repeat (9) @(negedge clk);
    check("pre-rst busy", {63'h0, busy}, 64'd1);
    n = done_cnt;
    reset = 1'b0;
    #1;
    check("arst busy", {63'h0, busy}, 64'd0);
    check("arst done", {63'h0, done}, 64'd0);
    model = 64'h0;
    check_hilo("arst", 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst nopulse", 64'(done_cnt - n), 64'd0);
    do_mult("9x9", 32'd9, 32'd9, 1'b0);

    // non-MULTU codes with start must be ignored
    foreach (codes[i]) begin
      @(negedge clk);
      dataA = $urandom; dataB = $urandom; signal = codes[i]; start = 1'b1;
      @(negedge clk);
      #1;
      check($sformatf("code%0d busy", i), {63'h0, busy}, 64'd0);
      check($sformatf("code%0d out", i), {32'h0, dataOut}, 64'd0);
      start = 1'b0;
      check_hilo($sformatf("code%0d", i), model);
    end

    for (int k = 0; k < 20; k++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (k == 0) a = 32'h0;
      if (k == 1) b = 32'h1;
      do_mult($sformatf("rnd%0d", k), a, b, k[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
